pool_engine: RTL
================

POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 21, meaning signed sample/result width.
REQ-002 SHALL have parameter WIN_W, default 4, meaning width of window-side input; window element count = win*win, held in a 2*WIN_W-bit counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  sample offered.
REQ-006 SHALL have port in_ready  output  1  sample accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  DATA_W  signed sample.
REQ-008 SHALL have port win  input  WIN_W  window side length; 0 treated as 1.
REQ-009 SHALL have port mode  input  1  0 = max pooling, 1 = min pooling.
REQ-010 SHALL have port out_valid  output  1  pooled result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-012 SHALL have port out_data  output  DATA_W  signed pooled result.
REQ-013 SHALL have port gmax  output  DATA_W  signed global maximum (POOL_GMAX_EN only).
REQ-014 SHALL have port gmax_clear  input  1  restart global maximum (POOL_GMAX_EN only).

Function
REQ-015 SHALL implement two states: IDLE (no window open) and ACC (window partially accumulated).
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational); no sample is lost under backpressure.
REQ-017 SHALL, on an accepted beat in IDLE, latch size = max(win,1)^2 and mode, load acc with in_data, set cnt = 1, and enter ACC; win/mode changes mid-window are ignored.
REQ-018 SHALL, on an accepted beat in ACC, update acc to the signed max (mode 0) or min (mode 1) of acc and in_data and increment cnt.
REQ-019 SHALL, on the accepted beat that makes the count equal size, register the final op(acc, in_data) into out_data, assert out_valid on the next cycle, and return to IDLE; size 1 completes on its first beat without entering ACC.
REQ-020 SHALL hold out_data and out_valid stable until out_valid && out_ready; out_valid clears the cycle after that handshake unless a new window completes in the same cycle, in which case out_valid stays high with new data.
REQ-021 SHALL use signed comparison over the full DATA_W; ties keep the existing acc value.
REQ-022 SHALL ignore in_data when in_valid is low; cnt, acc and state hold.

Reset
REQ-023 SHALL, while reset is high at a clock edge, force state = IDLE, cnt = 0, acc = most-negative value, out_valid = 0, out_data = 0, gmax = most-negative value (1 followed by DATA_W-1 zeros); reset overrides every other input, including an in-flight window, which is discarded.
REQ-024 SHALL drive in_ready = 1 during the first cycle after reset deasserts.

Configuration
REQ-025 SHALL compile the global-maximum tracker only when POOL_GMAX_EN is defined: gmax updates to in_data on any accepted beat where in_data > gmax, independent of mode and window.
REQ-026 SHALL, with POOL_GMAX_EN defined, load gmax with in_data when gmax_clear and an accepted beat coincide, or with most-negative when gmax_clear occurs alone.
REQ-027 SHALL, without POOL_GMAX_EN, omit gmax and gmax_clear ports and all related logic; pooling behaviour is identical.

Verification
REQ-028 SHALL cover: win=2, mode=0, beats 3,-7,9,1 with out_ready=1 -> one out_valid pulse, out_data=9, the cycle after the 4th beat.
REQ-029 SHALL cover: win=2, mode=1, beats 5,-2,-8,4 -> out_data=-8; then win=3 with nine beats of -1 -> out_data=-1 (negative ties).
REQ-030 SHALL cover: out_ready=0 held 5 cycles after a window completes -> out_valid/out_data stable, in_ready=0, no beats consumed; release -> next window proceeds unchanged.
REQ-031 SHALL cover: win=0 with beats 7,-3 -> two results 7 and -3 on consecutive cycles (window size 1).
REQ-032 SHALL cover: reset asserted after 2 of 4 beats -> out_valid=0, following 4 beats 1,2,3,4 produce out_data=4 (no carry-over).
REQ-033 SHALL cover (POOL_GMAX_EN): beats -5,-9 after reset -> gmax=-5; gmax_clear with beat -20 -> gmax=-20.

Source files
------------

// File: rtl/pool_engine.sv
// Streaming max/min pooling engine over win*win sample windows.
// Optional global-maximum tracker compiled in when POOL_GMAX_EN is defined.
module pool_engine #(
    parameter int DATA_W = 21,
    parameter int WIN_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [WIN_W-1:0]         win,
    input  logic                     mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data
`ifdef POOL_GMAX_EN
    ,
    output logic signed [DATA_W-1:0] gmax,
    input  logic                     gmax_clear
`endif
);

    localparam int CW = 2 * WIN_W;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;
    localparam logic signed [DATA_W-1:0] MOST_NEG =
        {1'b1, {(DATA_W-1){1'b0}}};

    logic [0:0]               state;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            size_r;
    logic                     mode_r;
    logic signed [DATA_W-1:0] acc;

    logic [WIN_W-1:0]         win_eff;
    logic [CW-1:0]            size_new;
    logic [CW-1:0]            cnt_next;
    logic                     accept;
    logic                     last;
    logic                     better;
    logic signed [DATA_W-1:0] merged;
    logic                     done;
    logic signed [DATA_W-1:0] done_data;

    // Handshake, window sizing and the max/min merge of acc with the new beat
    always_comb begin
        in_ready  = !out_valid || out_ready;
        accept    = in_valid && in_ready;
        win_eff   = (win == '0) ? WIN_W'(1) : win;
        size_new  = CW'(win_eff) * CW'(win_eff);
        cnt_next  = cnt + CW'(1);
        last      = (cnt_next == size_r);
        better    = mode_r ? (in_data < acc) : (in_data > acc);
        merged    = better ? in_data : acc;
        done      = 1'b0;
        done_data = merged;
        if (accept) begin
            if (state == ST_IDLE) begin
                done      = (size_new == CW'(1));
                done_data = in_data;
            end else begin
                done = last;
            end
        end
    end

    // Window accumulation state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            size_r <= '0;
            mode_r <= 1'b0;
            acc    <= MOST_NEG;
        end else if (accept) begin
            if (state == ST_IDLE) begin
                if (size_new != CW'(1)) begin
                    state  <= ST_ACC;
                    acc    <= in_data;
                    cnt    <= CW'(1);
                    size_r <= size_new;
                    mode_r <= mode;
                end
            end else if (last) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                acc <= merged;
                cnt <= cnt_next;
            end
        end
    end

    // Result register, held until the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_data  <= done_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef POOL_GMAX_EN
    // Running maximum of every accepted sample, independent of windows
    always_ff @(posedge clk) begin
        if (reset) begin
            gmax <= MOST_NEG;
        end else if (gmax_clear) begin
            gmax <= accept ? in_data : MOST_NEG;
        end else if (accept && (in_data > gmax)) begin
            gmax <= in_data;
        end
    end
`endif

endmodule
